// File: rtl/tlb_lookup_ctrl_if.sv
// Handshake bundle between tlb_lookup_ctrl and its requester / page walker.
// master = environment side (requester + walker), slave = the controller.
interface tlb_lookup_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_is_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_hit;
  logic        resp_fault;
  logic        walk_req_valid;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid;
  logic [19:0] walk_resp_ppn;
  logic [1:0]  walk_resp_perms;
  logic        walk_resp_fault;

  modport master (
    output req_valid, req_vaddr, req_is_write, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
    input  walk_req_valid, walk_req_vpn,
    output walk_resp_valid, walk_resp_ppn, walk_resp_perms, walk_resp_fault
  );

  modport slave (
    input  req_valid, req_vaddr, req_is_write, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
    output walk_req_valid, walk_req_vpn,
    input  walk_resp_valid, walk_resp_ppn, walk_resp_perms, walk_resp_fault
  );
endinterface

// File: rtl/tlb_lookup_ctrl.sv
// Lookup/refill controller for a set-associative TLB with per-entry LRU use counters.
// Optional hit/miss statistics counters are enabled by defining TLB_CTRL_STATS_EN.
module tlb_lookup_ctrl #(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 4,
  parameter int SET_INDEX_BITS = 4,
  parameter int LRU_BITS       = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  tlb_lookup_ctrl_if.slave             bus,
  output logic [SET_INDEX_BITS-1:0]    rd_set_index,
  input  logic [NUM_WAYS-1:0]          rd_valid_vec,
  input  logic [NUM_WAYS*20-1:0]       rd_vpn_flat,
  input  logic [NUM_WAYS*20-1:0]       rd_ppn_flat,
  input  logic [NUM_WAYS*2-1:0]        rd_perms_flat,
  input  logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_flat,
  output logic                         wr_en,
  output logic [SET_INDEX_BITS-1:0]    wr_set_index,
  output logic [1:0]                   wr_way,
  output logic                         wr_valid,
  output logic [19:0]                  wr_vpn,
  output logic [19:0]                  wr_ppn,
  output logic [1:0]                   wr_perms,
  output logic [LRU_BITS-1:0]          wr_lru_count,
  output logic                         lru_update_en,
  output logic [SET_INDEX_BITS-1:0]    lru_set_index,
  output logic [1:0]                   lru_way
`ifdef TLB_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_hits,
  output logic [31:0]                  stat_misses
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_FILL,
    S_RESP
  } state_t;

  localparam logic [SET_INDEX_BITS-1:0] SET_MASK = SET_INDEX_BITS'(NUM_SETS - 1);

  state_t      state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  victim_q, victim_d;
  logic [19:0] fill_ppn_q, fill_ppn_d;
  logic [1:0]  fill_perms_q, fill_perms_d;
  logic [31:0] resp_paddr_q, resp_paddr_d;
  logic        resp_hit_q, resp_hit_d;
  logic        resp_fault_q, resp_fault_d;

  logic [19:0]               vpn;
  logic [SET_INDEX_BITS-1:0] set_idx;

  assign vpn     = vaddr_q[31:12];
  assign set_idx = vaddr_q[12 +: SET_INDEX_BITS] & SET_MASK;

  logic [19:0]         way_ppn [NUM_WAYS];
  logic [1:0]          way_perms [NUM_WAYS];
  logic [LRU_BITS-1:0] way_lru [NUM_WAYS];
  logic [NUM_WAYS-1:0] hit_vec;

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
      assign way_ppn[gi]   = rd_ppn_flat[gi*20 +: 20];
      assign way_perms[gi] = rd_perms_flat[gi*2 +: 2];
      assign way_lru[gi]   = rd_lru_flat[gi*LRU_BITS +: LRU_BITS];
      assign hit_vec[gi]   = rd_valid_vec[gi] && (rd_vpn_flat[gi*20 +: 20] == vpn);
    end
  endgenerate

  // Multiple matching ways can only come from a corrupted array; the lowest one is used.
  logic       any_hit;
  logic [1:0] hit_way;
  always_comb begin
    any_hit = |hit_vec;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 2'(w);
    end
  end

  logic [19:0]         hit_ppn;
  logic [1:0]          hit_perms;
  logic [LRU_BITS-1:0] hit_lru;
  logic                hit_lru_sat;
  assign hit_ppn     = way_ppn[hit_way];
  assign hit_perms   = way_perms[hit_way];
  assign hit_lru     = way_lru[hit_way];
  assign hit_lru_sat = (hit_lru == {LRU_BITS{1'b1}});

  // Loads are never permission-checked, so the read bit is not consulted.
  logic unused_read_perm;
  assign unused_read_perm = hit_perms[0];

  // Victim: first invalid way, otherwise the least-used way (ties go to the lower index).
  logic                victim_way;
  logic [1:0]          victim_sel;
  logic [LRU_BITS-1:0] min_cnt;
  always_comb begin
    victim_way = 1'b0;
    victim_sel = '0;
    min_cnt    = way_lru[0];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!victim_way && !rd_valid_vec[w]) begin
        victim_way = 1'b1;
        victim_sel = 2'(w);
      end
    end
    if (!victim_way) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        if (way_lru[w] < min_cnt) begin
          min_cnt    = way_lru[w];
          victim_sel = 2'(w);
        end
      end
    end
  end

  assign rd_set_index  = set_idx;
  assign wr_set_index  = set_idx;
  assign wr_way        = victim_q;
  assign wr_valid      = 1'b1;
  assign wr_vpn        = vpn;
  assign wr_ppn        = fill_ppn_q;
  assign wr_perms      = fill_perms_q;
  assign wr_lru_count  = LRU_BITS'(1);
  assign lru_set_index = set_idx;
  assign lru_way       = hit_way;

  assign bus.resp_paddr   = resp_paddr_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_fault   = resp_fault_q;
  assign bus.walk_req_vpn = vpn;

  always_comb begin
    state_d            = state_q;
    vaddr_d            = vaddr_q;
    is_write_d         = is_write_q;
    victim_d           = victim_q;
    fill_ppn_d         = fill_ppn_q;
    fill_perms_d       = fill_perms_q;
    resp_paddr_d       = resp_paddr_q;
    resp_hit_d         = resp_hit_q;
    resp_fault_d       = resp_fault_q;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.walk_req_valid = 1'b0;
    wr_en              = 1'b0;
    lru_update_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          vaddr_d    = bus.req_vaddr;
          is_write_d = bus.req_is_write;
          state_d    = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (any_hit) begin
          // A faulting store still counts as a use of the entry.
          lru_update_en = !hit_lru_sat;
          resp_hit_d    = 1'b1;
          resp_fault_d  = is_write_q && !hit_perms[1];
          resp_paddr_d  = (is_write_q && !hit_perms[1]) ? 32'd0 : {hit_ppn, vaddr_q[11:0]};
          state_d       = S_RESP;
        end else begin
          victim_d = victim_sel;
          state_d  = S_WALK;
        end
      end

      S_WALK: begin
        bus.walk_req_valid = 1'b1;
        if (bus.walk_resp_valid) begin
          resp_hit_d = 1'b0;
          if (bus.walk_resp_fault) begin
            resp_fault_d = 1'b1;
            resp_paddr_d = 32'd0;
            state_d      = S_RESP;
          end else begin
            fill_ppn_d   = bus.walk_resp_ppn;
            fill_perms_d = bus.walk_resp_perms;
            resp_fault_d = is_write_q && !bus.walk_resp_perms[1];
            resp_paddr_d = (is_write_q && !bus.walk_resp_perms[1]) ? 32'd0
                                                                   : {bus.walk_resp_ppn, vaddr_q[11:0]};
            state_d      = S_FILL;
          end
        end
      end

      S_FILL: begin
        wr_en   = 1'b1;
        state_d = S_RESP;
      end

      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vaddr_q      <= '0;
      is_write_q   <= 1'b0;
      victim_q     <= '0;
      fill_ppn_q   <= '0;
      fill_perms_q <= '0;
      resp_paddr_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vaddr_q      <= vaddr_d;
      is_write_q   <= is_write_d;
      victim_q     <= victim_d;
      fill_ppn_q   <= fill_ppn_d;
      fill_perms_q <= fill_perms_d;
      resp_paddr_q <= resp_paddr_d;
      resp_hit_q   <= resp_hit_d;
      resp_fault_q <= resp_fault_d;
    end
  end

`ifdef TLB_CTRL_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (state_q == S_LOOKUP) begin
      if (any_hit) begin
        if (stat_hits_q != 32'hFFFF_FFFF) stat_hits_d = stat_hits_q + 32'd1;
      end else begin
        if (stat_misses_q != 32'hFFFF_FFFF) stat_misses_d = stat_misses_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Randomized bench for tlb_lookup_ctrl: emulates the storage array and walker, and predicts
// every transaction from a transaction-level TLB model (hit/miss, victim, LRU, faults, latency).
module tb_tlb_lookup_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  tlb_lookup_ctrl_if bus_if ();

  logic [3:0]  rd_set_index;
  logic [3:0]  rd_valid_vec;
  logic [79:0] rd_vpn_flat, rd_ppn_flat;
  logic [7:0]  rd_perms_flat;
  logic [11:0] rd_lru_flat;
  logic        wr_en, wr_valid, lru_update_en;
  logic [3:0]  wr_set_index, lru_set_index;
  logic [1:0]  wr_way, lru_way, wr_perms;
  logic [19:0] wr_vpn, wr_ppn;
  logic [2:0]  wr_lru_count;
`ifdef TLB_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  tlb_lookup_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .rd_set_index(rd_set_index), .rd_valid_vec(rd_valid_vec),
    .rd_vpn_flat(rd_vpn_flat), .rd_ppn_flat(rd_ppn_flat),
    .rd_perms_flat(rd_perms_flat), .rd_lru_flat(rd_lru_flat),
    .wr_en(wr_en), .wr_set_index(wr_set_index), .wr_way(wr_way), .wr_valid(wr_valid),
    .wr_vpn(wr_vpn), .wr_ppn(wr_ppn), .wr_perms(wr_perms), .wr_lru_count(wr_lru_count),
    .lru_update_en(lru_update_en), .lru_set_index(lru_set_index), .lru_way(lru_way)
`ifdef TLB_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  // Storage array emulation (combinational read, clocked write / LRU increment).
  logic        s_valid [16][4];
  logic [19:0] s_vpn [16][4];
  logic [19:0] s_ppn [16][4];
  logic [1:0]  s_perms [16][4];
  logic [2:0]  s_lru [16][4];
  int wr_cnt = 0, lru_cnt = 0, both_cnt = 0;
  logic [1:0] last_wr_way, last_lru_way;
  logic [3:0] last_wr_set, last_lru_set;
  logic [2:0] last_wr_lru;

  always_comb begin
    rd_valid_vec  = '0;
    rd_vpn_flat   = '0;
    rd_ppn_flat   = '0;
    rd_perms_flat = '0;
    rd_lru_flat   = '0;
    for (int w = 0; w < 4; w++) begin
      rd_valid_vec[w]        = s_valid[rd_set_index][w];
      rd_vpn_flat[w*20 +: 20] = s_vpn[rd_set_index][w];
      rd_ppn_flat[w*20 +: 20] = s_ppn[rd_set_index][w];
      rd_perms_flat[w*2 +: 2] = s_perms[rd_set_index][w];
      rd_lru_flat[w*3 +: 3]   = s_lru[rd_set_index][w];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) begin
          s_valid[s][w] <= 1'b0;
          s_vpn[s][w]   <= '0;
          s_ppn[s][w]   <= '0;
          s_perms[s][w] <= '0;
          s_lru[s][w]   <= '0;
        end
    end else begin
      if (wr_en) begin
        s_valid[wr_set_index][wr_way] <= wr_valid;
        s_vpn[wr_set_index][wr_way]   <= wr_vpn;
        s_ppn[wr_set_index][wr_way]   <= wr_ppn;
        s_perms[wr_set_index][wr_way] <= wr_perms;
        s_lru[wr_set_index][wr_way]   <= wr_lru_count;
        wr_cnt      <= wr_cnt + 1;
        last_wr_way <= wr_way;
        last_wr_set <= wr_set_index;
        last_wr_lru <= wr_lru_count;
      end
      if (lru_update_en) begin
        s_lru[lru_set_index][lru_way] <= s_lru[lru_set_index][lru_way] + 3'd1;
        lru_cnt      <= lru_cnt + 1;
        last_lru_way <= lru_way;
        last_lru_set <= lru_set_index;
      end
      if (wr_en && lru_update_en) both_cnt <= both_cnt + 1;
    end
  end

  // Transaction-level reference TLB.
  logic        m_valid [16][4];
  logic [19:0] m_vpn [16][4];
  logic [19:0] m_ppn [16][4];
  logic [1:0]  m_perms [16][4];
  int          m_use [16][4];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_req(input logic [31:0] va, input logic wr, input logic [19:0] wppn,
                        input logic [1:0] wperm, input logic wfault, input int wdelay,
                        input int rdelay, output logic [31:0] got_pa);
    logic [19:0] vpn;
    int set, hw, vic, exp_lat, exp_wr, exp_lru, wr0, lru0, n, wseen;
    logic hit, fault;
    logic [31:0] exp_pa;
    vpn = va[31:12];
    set = int'(vpn[3:0]);
    hit = 1'b0; hw = 0; vic = -1;
    for (int w = 0; w < 4; w++)
      if (!hit && m_valid[set][w] && m_vpn[set][w] == vpn) begin hit = 1'b1; hw = w; end
    if (hit) begin
      fault   = wr && !m_perms[set][hw][1];
      exp_pa  = fault ? 32'd0 : {m_ppn[set][hw], va[11:0]};
      exp_lru = (m_use[set][hw] < 7) ? 1 : 0;
      exp_wr  = 0;
      exp_lat = 2;
      if (exp_lru == 1) m_use[set][hw]++;
    end else begin
      for (int w = 0; w < 4; w++) if (vic < 0 && !m_valid[set][w]) vic = w;
      if (vic < 0) begin
        vic = 0;
        for (int w = 1; w < 4; w++) if (m_use[set][w] < m_use[set][vic]) vic = w;
      end
      fault   = wfault || (wr && !wperm[1]);
      exp_pa  = fault ? 32'd0 : {wppn, va[11:0]};
      exp_lru = 0;
      exp_wr  = wfault ? 0 : 1;
      exp_lat = wfault ? 3 + wdelay : 4 + wdelay;
      if (!wfault) begin
        m_valid[set][vic] = 1'b1; m_vpn[set][vic] = vpn; m_ppn[set][vic] = wppn;
        m_perms[set][vic] = wperm; m_use[set][vic] = 1;
      end
    end

    @(negedge clk);
    check("req_ready_idle", bus_if.req_ready, 1);
    wr0 = wr_cnt; lru0 = lru_cnt;
    bus_if.req_valid = 1'b1; bus_if.req_vaddr = va; bus_if.req_is_write = wr;
    @(negedge clk);
    bus_if.req_valid = 1'b0; bus_if.req_vaddr = $urandom; bus_if.req_is_write = 1'($urandom);
    n = 1; wseen = 0;
    while (!bus_if.resp_valid && n < 200) begin
      if (bus_if.walk_req_valid) begin
        if (wseen == 0) check("walk_vpn", bus_if.walk_req_vpn, vpn);
        if (wseen == wdelay) begin
          bus_if.walk_resp_valid = 1'b1; bus_if.walk_resp_ppn = wppn;
          bus_if.walk_resp_perms = wperm; bus_if.walk_resp_fault = wfault;
        end
        wseen++;
      end
      @(negedge clk);
      bus_if.walk_resp_valid = 1'b0;
      n++;
    end
    got_pa = bus_if.resp_paddr;
    check("walk_requested", wseen > 0, !hit);
    check("latency", n, exp_lat);
    check("resp_valid", bus_if.resp_valid, 1);
    check("resp_hit", bus_if.resp_hit, hit);
    check("resp_fault", bus_if.resp_fault, fault);
    check("resp_paddr", bus_if.resp_paddr, exp_pa);
    check("req_ready_busy", bus_if.req_ready, 0);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check("hold_valid", bus_if.resp_valid, 1);
      check("hold_paddr", bus_if.resp_paddr, exp_pa);
      check("hold_req_ready", bus_if.req_ready, 0);
    end
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    check("resp_dropped", bus_if.resp_valid, 0);
    check("wr_pulses", wr_cnt - wr0, exp_wr);
    if (exp_wr == 1) begin
      check("wr_way", last_wr_way, vic);
      check("wr_set", last_wr_set, set);
      check("wr_lru", last_wr_lru, 1);
    end
    check("lru_pulses", lru_cnt - lru0, exp_lru);
    if (exp_lru == 1) check("lru_way", {last_lru_set, last_lru_way}, {set[3:0], hw[1:0]});
    for (int w = 0; w < 4; w++) begin
      check("array_valid", s_valid[set][w], m_valid[set][w]);
      if (m_valid[set][w])
        check("array_entry", {s_vpn[set][w], s_ppn[set][w], s_perms[set][w], s_lru[set][w]},
              {m_vpn[set][w], m_ppn[set][w], m_perms[set][w], m_use[set][w][2:0]});
    end
  endtask

  initial begin
    logic [31:0] pa;
    int wr0;
    bus_if.req_valid = 1'b0; bus_if.req_vaddr = '0; bus_if.req_is_write = 1'b0;
    bus_if.resp_ready = 1'b0; bus_if.walk_resp_valid = 1'b0; bus_if.walk_resp_ppn = '0;
    bus_if.walk_resp_perms = '0; bus_if.walk_resp_fault = 1'b0;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0; m_vpn[s][w] = '0; m_ppn[s][w] = '0; m_perms[s][w] = '0; m_use[s][w] = 0;
      end
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus_if.req_ready, 1);
    check("rst_resp_valid", bus_if.resp_valid, 0);
    check("rst_walk_req", bus_if.walk_req_valid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_lru_update", lru_update_en, 0);
    check("rst_resp_fields", {bus_if.resp_paddr, bus_if.resp_hit, bus_if.resp_fault}, 0);

    // Cold miss, then hit to the same page.
    do_req(32'h12345ABC, 0, 20'h00ABC, 2'b01, 0, 1, 0, pa);
    check("cold_paddr", pa, 32'h00ABCABC);
    check("cold_fill_slot", {last_wr_set, last_wr_way}, {4'd5, 2'd0});
    do_req(32'h12345004, 0, 20'h0, 2'b01, 0, 0, 0, pa);
    check("reaccess_paddr", pa, 32'h00ABC004);
    // Build counts 4,1,2,1 in set 5, then force an eviction.
    do_req(32'h12345000, 0, 20'h0, 2'b01, 0, 0, 0, pa);
    do_req(32'h12345000, 0, 20'h0, 2'b01, 0, 0, 0, pa);
    do_req(32'h00015000, 0, 20'h11111, 2'b11, 0, 0, 1, pa);
    do_req(32'h00025000, 0, 20'h22222, 2'b11, 0, 2, 0, pa);
    do_req(32'h00025100, 0, 20'h0, 2'b11, 0, 0, 0, pa);
    do_req(32'h00035000, 0, 20'h33333, 2'b11, 0, 0, 0, pa);
    do_req(32'h00045000, 1, 20'h44444, 2'b11, 0, 1, 0, pa);
    check("evict_way", last_wr_way, 1);
    // Saturate way 0, then a store to its read-only page.
    for (int i = 0; i < 4; i++) do_req(32'h12345000, 0, 20'h0, 2'b01, 0, 0, 0, pa);
    do_req(32'h12345010, 1, 20'h0, 2'b01, 0, 0, 0, pa);
    check("store_ro_paddr", pa, 32'h0);
    // Walk fault: no fill.
    do_req(32'h00055123, 0, 20'h55555, 2'b11, 1, 2, 0, pa);
    // Reset while walking: no write, no response, late walk response ignored.
    @(negedge clk);
    wr0 = wr_cnt;
    bus_if.req_valid = 1'b1; bus_if.req_vaddr = 32'h00065123; bus_if.req_is_write = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    for (int i = 0; i < 10 && !bus_if.walk_req_valid; i++) @(negedge clk);
    check("abort_walk_started", bus_if.walk_req_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_idle", bus_if.req_ready, 1);
    check("abort_walk_dropped", bus_if.walk_req_valid, 0);
    bus_if.walk_resp_valid = 1'b1; bus_if.walk_resp_ppn = 20'h66666;
    bus_if.walk_resp_perms = 2'b11; bus_if.walk_resp_fault = 1'b0;
    @(negedge clk);
    bus_if.walk_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", bus_if.resp_valid, 0);
      @(negedge clk);
    end
    check("abort_no_write", wr_cnt - wr0, 0);
    // Requester stalls the response.
    do_req(32'h00045008, 0, 20'h0, 2'b11, 0, 0, 5, pa);

    for (int t = 0; t < 250; t++) begin
      logic [19:0] rvpn;
      rvpn = 20'(($urandom_range(0, 5) << 4) | $urandom_range(0, 3));
      do_req({rvpn, 12'($urandom)}, 1'($urandom), 20'($urandom), 2'($urandom),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2), pa);
    end

    check("wr_lru_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
